pc_sequencer: RTL and testbench

- Owns the architectural PC register for the fetch stage and drives the next-PC mux select (pc_choose) and fetch squash (disable_pc) into the IF stage.
- Arbitrates between sequential fetch, branch, register jump, absolute jump, interrupt entry and exception return.
- Holds the exception PC (cpc) and a small RUN/ISR state machine that masks nested interrupts.
- Sits between hazard/branch-resolution logic and the IF stage. IF returns npc, which this block registers as pc.

---
 rtl/pc_sequencer_pkg.sv | 28 ++
 rtl/pc_sequencer_pc_sel_arbiter.sv | 60 ++++++
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_pkg
// Description : Shared constants for the PC sequencer.
//               - IF next-PC mux select codes (pc_choose).
//               - RUN/ISR state encoding.
//               - Interrupt entry vector.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

    // pc_choose encoding; codes 6 and 7 are never driven
    localparam logic [2:0] PC_SEL_SEQ    = 3'd0;  // PC + 4
    localparam logic [2:0] PC_SEL_BRANCH = 3'd1;  // conditional branch target
    localparam logic [2:0] PC_SEL_JR     = 3'd2;  // register-indirect jump
    localparam logic [2:0] PC_SEL_JUMP   = 3'd3;  // absolute jump
    localparam logic [2:0] PC_SEL_INT    = 3'd4;  // interrupt entry vector
    localparam logic [2:0] PC_SEL_ERET   = 3'd5;  // return to saved cpc

    // Sequencer state encoding
    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_ISR = 1'b1;

    // Address the IF mux loads when pc_choose selects interrupt entry
    localparam logic [31:0] INT_ENTRY = 32'h0000_0004;

endpackage : pc_sequencer_pkg
`default_nettype wire

// File: rtl/pc_sequencer_pc_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pc_sel_arbiter
// Description : Combinational priority encoder for the IF next-PC mux.
//               Priority, highest first: interrupt entry, eret (ISR only),
//               branch, register jump, absolute jump, sequential.
//               A stall forces the sequential select and suppresses squash.
// Ports       : stall, branch_taken, jr, jump, eret - request inputs
//               int_pending, state                  - sequencer status
//               pc_choose  - IF mux select
//               disable_pc - squash the current fetch
//               take_int   - an interrupt is taken this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sel_arbiter
    import pc_sequencer_pkg::*;
(
    input  logic       stall,
    input  logic       branch_taken,
    input  logic       jr,
    input  logic       jump,
    input  logic       eret,
    input  logic       int_pending,
    input  logic [0:0] state,
    output logic [2:0] pc_choose,
    output logic       disable_pc,
    output logic       take_int
);

    logic w_redirect;

    // Any control-flow redirect in flight defers the interrupt so that the
    // saved cpc is always a well-defined sequential PC.
    assign w_redirect = branch_taken | jr | jump | eret;

    always_comb begin
        take_int  = 1'b0;
        pc_choose = PC_SEL_SEQ;

        if (!stall) begin
            if ((state == ST_RUN) && int_pending && !w_redirect) begin
                take_int  = 1'b1;
                pc_choose = PC_SEL_INT;
            end else if (eret && (state == ST_ISR)) begin
                pc_choose = PC_SEL_ERET;
            end else if (branch_taken) begin
                pc_choose = PC_SEL_BRANCH;
            end else if (jr) begin
                pc_choose = PC_SEL_JR;
            end else if (jump) begin
                pc_choose = PC_SEL_JUMP;
            end
        end
    end

    // pc_choose is already forced to sequential under stall
    assign disable_pc = (pc_choose != PC_SEL_SEQ);

endmodule : pc_sel_arbiter
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Owns the fetch-stage PC register, the saved exception PC
//               (cpc), a pending-interrupt latch and a RUN/ISR state machine
//               that masks nested interrupts. Drives the IF next-PC mux
//               select and the fetch squash.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               npc             - next PC returned by the IF mux
//               stall           - hold the PC this cycle
//               branch_taken, jr, jump, eret - redirect requests
//               int_req, int_en - interrupt request (level) and enable
//               pc, cpc         - current fetch PC, saved exception PC
//               pc_choose       - IF mux select
//               disable_pc      - squash the current fetch
//               in_isr, int_ack - ISR status, interrupt-taken pulse
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] CPC_RESET = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jr,
    input  logic        jump,
    input  logic        eret,
    input  logic        int_req,
    input  logic        int_en,
    output logic [31:0] pc,
    output logic [31:0] cpc,
    output logic [2:0]  pc_choose,
    output logic        disable_pc,
    output logic        in_isr,
    output logic        int_ack
);

    logic [31:0] r_pc;
    logic [31:0] r_cpc;
    logic [0:0]  r_state;
    logic        r_int_pending;

    logic        w_take_int;
    logic [2:0]  w_pc_choose;
    logic        w_disable_pc;

    pc_sel_arbiter u_pc_sel_arbiter (
        .stall        (stall),
        .branch_taken (branch_taken),
        .jr           (jr),
        .jump         (jump),
        .eret         (eret),
        .int_pending  (r_int_pending),
        .state        (r_state),
        .pc_choose    (w_pc_choose),
        .disable_pc   (w_disable_pc),
        .take_int     (w_take_int)
    );

    // PC register: one-cycle latency from npc, held under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (!stall) begin
            r_pc <= npc;
        end
    end

    // Pending latch keeps short int_req pulses until they can be taken.
    // Taking the interrupt clears it even if int_req is still high; a held
    // level request simply re-arms it on the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_pending <= 1'b0;
        end else if (w_take_int) begin
            r_int_pending <= 1'b0;
        end else if (int_req && int_en) begin
            r_int_pending <= 1'b1;
        end
    end

    // RUN/ISR state machine plus cpc capture. cpc saves the squashed PC so
    // the interrupted instruction is re-executed after eret.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cpc   <= CPC_RESET;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_take_int) begin
                        r_state <= ST_ISR;
                        r_cpc   <= r_pc;
                    end
                end
                ST_ISR: begin
                    if (eret && !stall) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign pc         = r_pc;
    assign cpc        = r_cpc;
    assign pc_choose  = w_pc_choose;
    assign disable_pc = w_disable_pc;
    // Status outputs are held low while reset is asserted.
    assign in_isr     = (r_state == ST_ISR) && !rst;
    assign int_ack    = w_take_int && !rst;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. A behavioural model
//               tracks pc, cpc, pending interrupt and ISR mode; directed
//               scenarios are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam logic [31:0] C_RESET_PC  = 32'h0000_1000;
    localparam logic [31:0] C_CPC_RESET = 32'h0000_0BAD;

    logic        clk;
    logic        rst;
    logic [31:0] npc;
    logic        stall, branch_taken, jr, jump, eret, int_req, int_en;
    logic [31:0] pc, cpc;
    logic [2:0]  pc_choose;
    logic        disable_pc, in_isr, int_ack;

    int n_vec;
    int n_err;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_cpc;
    bit          m_isr;
    bit          m_pend;

    pc_sequencer #(
        .RESET_PC  (C_RESET_PC),
        .CPC_RESET (C_CPC_RESET)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .npc          (npc),
        .stall        (stall),
        .branch_taken (branch_taken),
        .jr           (jr),
        .jump         (jump),
        .eret         (eret),
        .int_req      (int_req),
        .int_en       (int_en),
        .pc           (pc),
        .cpc          (cpc),
        .pc_choose    (pc_choose),
        .disable_pc   (disable_pc),
        .in_isr       (in_isr),
        .int_ack      (int_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs and
    // registered state, then advance the model across the rising edge.
    task automatic step(input bit i_rst, input bit i_stall, input bit i_br,
                        input bit i_jr, input bit i_jump, input bit i_eret,
                        input bit i_ireq, input bit i_ien, input logic [31:0] tgt);
        bit          take;
        logic [2:0]  sel;
        logic [31:0] nxt;

        @(negedge clk);
        rst = i_rst; stall = i_stall; branch_taken = i_br; jr = i_jr;
        jump = i_jump; eret = i_eret; int_req = i_ireq; int_en = i_ien;

        // Interrupts wait for a quiet, unstalled cycle in RUN mode.
        take = !m_isr && m_pend && !i_stall && !(i_br || i_jr || i_jump || i_eret);
        if (i_stall)             sel = 3'd0;
        else if (take)           sel = 3'd4;
        else if (i_eret && m_isr) sel = 3'd5;
        else if (i_br)           sel = 3'd1;
        else if (i_jr)           sel = 3'd2;
        else if (i_jump)         sel = 3'd3;
        else                     sel = 3'd0;

        // IF mux behaviour
        case (sel)
            3'd0:    nxt = m_pc + 32'd4;
            3'd4:    nxt = INT_ENTRY;
            3'd5:    nxt = m_cpc;
            default: nxt = tgt;
        endcase
        npc = nxt;
        #1;

        chk("pc", pc, m_pc);
        chk("cpc", cpc, m_cpc);
        if (i_rst) begin
            chk("in_isr_rst", {31'd0, in_isr}, 32'd0);
            chk("int_ack_rst", {31'd0, int_ack}, 32'd0);
        end else begin
            chk("pc_choose", {29'd0, pc_choose}, {29'd0, sel});
            chk("disable_pc", {31'd0, disable_pc}, {31'd0, sel != 3'd0});
            chk("in_isr", {31'd0, in_isr}, {31'd0, m_isr});
            chk("int_ack", {31'd0, int_ack}, {31'd0, take});
        end

        @(posedge clk);
        if (i_rst) begin
            m_pc = C_RESET_PC; m_cpc = C_CPC_RESET; m_isr = 0; m_pend = 0;
        end else begin
            if (!i_stall) m_pc = nxt;
            if (take) begin
                m_cpc = m_pc_prev(nxt, i_stall);
                m_isr = 1;
                m_pend = 0;
            end else begin
                if (i_ireq && i_ien) m_pend = 1;
                if (m_isr && sel == 3'd5) m_isr = 0;
            end
        end
    endtask

    // cpc captures the PC that was current in the take cycle; this helper
    // recovers it from the saved copy taken before the model update.
    logic [31:0] m_pc_save;
    function automatic logic [31:0] m_pc_prev(input logic [31:0] unused_nxt, input bit unused_st);
        return m_pc_save;
    endfunction

    task automatic free(input int n);
        for (int k = 0; k < n; k++) begin
            m_pc_save = m_pc;
            step(0, 0, 0, 0, 0, 0, 0, 0, 32'd0);
        end
    endtask

    task automatic cyc(input bit i_rst, input bit i_stall, input bit i_br,
                       input bit i_jr, input bit i_jump, input bit i_eret,
                       input bit i_ireq, input bit i_ien, input logic [31:0] tgt);
        m_pc_save = m_pc;
        step(i_rst, i_stall, i_br, i_jr, i_jump, i_eret, i_ireq, i_ien, tgt);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1; npc = 0; stall = 0; branch_taken = 0; jr = 0; jump = 0;
        eret = 0; int_req = 0; int_en = 0;
        m_pc = 32'hx; m_cpc = 32'hx; m_isr = 0; m_pend = 0;

        // Reset; the first check window sees uninitialised registers, so the
        // model is forced to the reset state before the first compare.
        @(posedge clk);
        m_pc = C_RESET_PC; m_cpc = C_CPC_RESET;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Jump to 0 so the free-running sequence starts at 0,4,8,C
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 32'h0);
        free(4);                                   // pc reaches 0x10
        cyc(0, 0, 1, 0, 1, 0, 0, 0, 32'h40);       // branch beats jump
        cyc(0, 1, 0, 0, 1, 0, 0, 0, 32'h100);      // stalled jump held
        cyc(0, 1, 0, 0, 1, 0, 0, 0, 32'h100);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 32'h100);      // jump now taken

        // Interrupt pulse alongside jr: jr first, interrupt on next cycle
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 32'h20);
        cyc(0, 0, 0, 1, 0, 0, 1, 1, 32'h80);
        free(1);                                   // take_int, pc -> 0x4
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);            // nested request latched
        cyc(0, 0, 0, 0, 0, 1, 0, 1, 0);            // eret -> cpc
        free(1);                                   // pending interrupt taken
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);            // pending again, in ISR
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);            // reset mid-ISR
        free(3);                                   // no spurious int_ack
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);            // disabled request ignored
        free(2);

        // Address wrap
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC);
        free(2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(99) < 1),
                ($urandom_range(99) < 20),
                ($urandom_range(99) < 12),
                ($urandom_range(99) < 10),
                ($urandom_range(99) < 10),
                ($urandom_range(99) < 15),
                ($urandom_range(99) < 15),
                ($urandom_range(99) < 75),
                $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire
